// File: rtl/transfer_datapath.sv
// transfer_datapath
//   Datapath for the memory-to-memory transfer. Executes the per-cycle
//   IncA/IncB/WEA/WEB commands from the transfer controller: loads memory A,
//   streams it through a two-stage read pipeline, and stores the larger
//   word of each adjacent A pair into memory B.
//
// Ports
//   clock    rising-edge clock
//   Reset    synchronous active-low reset (pointers, pipeline, counter only)
//   IncA/B   advance AddrA/AddrB this edge (wrap at depth)
//   WEA      MemA[AddrA] <= DataInA this edge
//   WEB      MemB[AddrB] <= DataB this edge
//   DataInA  load data for memory A
//   AddrA/B  current memory addresses
//   ACur     registered MemA[AddrA]; APrev is ACur one cycle later
//   DataB    unsigned max(ACur, APrev), combinational
//   DOutB    registered MemB[AddrB] (monitor)
//   BCount   MemB writes since reset, saturating at B_DEPTH
//   BFull    BCount == B_DEPTH
module transfer_datapath #(
  parameter int DATA_W  = 8,
  parameter int A_DEPTH = 8,
  parameter int B_DEPTH = 4,
  localparam int AW = $clog2(A_DEPTH),
  localparam int BW = $clog2(B_DEPTH)
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              IncA,
  input  logic              IncB,
  input  logic              WEA,
  input  logic              WEB,
  input  logic [DATA_W-1:0] DataInA,
  output logic [AW-1:0]     AddrA,
  output logic [BW-1:0]     AddrB,
  output logic [DATA_W-1:0] ACur,
  output logic [DATA_W-1:0] APrev,
  output logic [DATA_W-1:0] DataB,
  output logic [DATA_W-1:0] DOutB,
  output logic [BW:0]       BCount,
  output logic              BFull
);

  localparam logic [BW:0] B_FULL_CNT = (BW+1)'(B_DEPTH);

  // Memories carry no reset: contents survive a mid-transfer reset.
  logic [DATA_W-1:0] mem_a [A_DEPTH];
  logic [DATA_W-1:0] mem_b [B_DEPTH];

  logic [AW-1:0]     addr_a_q, addr_a_d;
  logic [BW-1:0]     addr_b_q, addr_b_d;
  logic [DATA_W-1:0] acur_q,   acur_d;
  logic [DATA_W-1:0] aprev_q,  aprev_d;
  logic [DATA_W-1:0] doutb_q,  doutb_d;
  logic [BW:0]       bcount_q, bcount_d;
  logic [DATA_W-1:0] data_b;

  always_comb begin
    data_b   = (acur_q >= aprev_q) ? acur_q : aprev_q;
    // Depths are powers of two, so natural overflow gives the wrap.
    addr_a_d = IncA ? addr_a_q + 1'b1 : addr_a_q;
    addr_b_d = IncB ? addr_b_q + 1'b1 : addr_b_q;
    // Reads use the pre-increment address and see the pre-write word.
    acur_d   = mem_a[addr_a_q];
    aprev_d  = acur_q;
    doutb_d  = mem_b[addr_b_q];
    bcount_d = (WEB && (bcount_q < B_FULL_CNT)) ? bcount_q + 1'b1 : bcount_q;
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      acur_q   <= '0;
      aprev_q  <= '0;
      doutb_q  <= '0;
      bcount_q <= '0;
    end else begin
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      acur_q   <= acur_d;
      aprev_q  <= aprev_d;
      doutb_q  <= doutb_d;
      bcount_q <= bcount_d;
    end
  end

  // Reset suppresses writes so a reset cycle has no side effects on data.
  always_ff @(posedge clock) begin
    if (Reset && WEA) mem_a[addr_a_q] <= DataInA;
  end

  // BFull deliberately does not gate writes: a full buffer wraps and overwrites.
  always_ff @(posedge clock) begin
    if (Reset && WEB) mem_b[addr_b_q] <= data_b;
  end

  assign AddrA  = addr_a_q;
  assign AddrB  = addr_b_q;
  assign ACur   = acur_q;
  assign APrev  = aprev_q;
  assign DataB  = data_b;
  assign DOutB  = doutb_q;
  assign BCount = bcount_q;
  assign BFull  = (bcount_q == B_FULL_CNT);

endmodule

// File: tb/tb_transfer_datapath.sv
module tb_transfer_datapath;
  localparam int DW = 8, AD = 8, BD = 4, AW = 3, BW = 2;
  localparam int VW = AW + BW + 4*DW + BW + 2;

  logic          clock = 1'b0;
  logic          Reset, IncA, IncB, WEA, WEB;
  logic [DW-1:0] DataInA;
  logic [AW-1:0] AddrA;
  logic [BW-1:0] AddrB;
  logic [DW-1:0] ACur, APrev, DataB, DOutB;
  logic [BW:0]   BCount;
  logic          BFull;

  transfer_datapath #(.DATA_W(DW), .A_DEPTH(AD), .B_DEPTH(BD)) dut (
    .clock(clock), .Reset(Reset), .IncA(IncA), .IncB(IncB), .WEA(WEA), .WEB(WEB),
    .DataInA(DataInA), .AddrA(AddrA), .AddrB(AddrB), .ACur(ACur), .APrev(APrev),
    .DataB(DataB), .DOutB(DOutB), .BCount(BCount), .BFull(BFull)
  );

  always #5 clock = ~clock;

  typedef struct { logic [VW-1:0] val; logic [VW-1:0] mask; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  // Reference model; valid bits track words never written (unknown content).
  logic [DW-1:0] m_a [AD];
  bit            va  [AD];
  logic [DW-1:0] m_b [BD];
  bit            vb  [BD];
  logic [AW-1:0] m_aa;
  logic [BW-1:0] m_ab;
  logic [DW-1:0] m_acur, m_aprev, m_doutb;
  bit            v_acur, v_aprev, v_doutb;
  logic [BW:0]   m_bc;

  function automatic logic [VW-1:0] obs();
    return {AddrA, AddrB, ACur, APrev, DataB, DOutB, BCount, BFull};
  endfunction

  // Drive one cycle of commands, push the model's expectation, advance past the edge.
  task automatic tick(input logic r, ia, ib, wa, wb, input logic [DW-1:0] din);
    logic [DW-1:0] db;
    bit vdb;
    exp_t e;
    Reset = r; IncA = ia; IncB = ib; WEA = wa; WEB = wb; DataInA = din;
    if (!r) begin
      m_aa = '0; m_ab = '0; m_acur = '0; m_aprev = '0; m_doutb = '0; m_bc = '0;
      v_acur = 1; v_aprev = 1; v_doutb = 1;
    end else begin
      db  = (m_acur >= m_aprev) ? m_acur : m_aprev;
      vdb = v_acur && v_aprev;
      m_doutb = m_b[m_ab]; v_doutb = vb[m_ab];
      if (wb) begin
        m_b[m_ab] = db; vb[m_ab] = vdb;
        if (m_bc < BD) m_bc = m_bc + 1'b1;
      end
      m_aprev = m_acur; v_aprev = v_acur;
      m_acur = m_a[m_aa]; v_acur = va[m_aa];
      if (wa) begin m_a[m_aa] = din; va[m_aa] = 1; end
      if (ia) m_aa = m_aa + 1'b1;
      if (ib) m_ab = m_ab + 1'b1;
    end
    db  = (m_acur >= m_aprev) ? m_acur : m_aprev;
    vdb = v_acur && v_aprev;
    e.val  = {m_aa, m_ab, m_acur, m_aprev, db, m_doutb, m_bc, (m_bc == BD)};
    e.mask = {{AW{1'b1}}, {BW{1'b1}}, {DW{v_acur}}, {DW{v_aprev}}, {DW{vdb}},
              {DW{v_doutb}}, {(BW+2){1'b1}}};
    sb.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 1, 1, 1, 8'hff);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL reset_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
    end
    checks++;
    if ({AddrA, AddrB, ACur, APrev, DataB, BCount, BFull} !== '0) begin
      errors++; $display("FAIL reset_state got %h want 0", {AddrA, AddrB, ACur, APrev, DataB, BCount, BFull});
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [DW-1:0] vals [8] = '{10, 3, 7, 9, 2, 8, 5, 6};
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 0, 1, 0, vals[i]);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL load_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
    end
    checks++;
    if (AddrA !== 3'd0) begin errors++; $display("FAIL load_wrap got %0d want 0", AddrA); end
  endtask

  task automatic test_stream();
    exp_t e;
    logic [DW-1:0] acur_x [8] = '{10, 3, 7, 9, 2, 8, 5, 6};
    logic [DW-1:0] datb_x [7] = '{10, 7, 9, 9, 8, 8, 6};
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 0, 0, 0, 8'h00);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL stream_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
      checks++;
      if (ACur !== acur_x[i]) begin errors++; $display("FAIL stream_acur[%0d] got %0d want %0d", i, ACur, acur_x[i]); end
      if (i > 0) begin
        checks++;
        if (DataB !== datb_x[i-1]) begin errors++; $display("FAIL stream_datab[%0d] got %0d want %0d", i, DataB, datb_x[i-1]); end
      end
    end
  endtask

  // Five WEB+IncB pulses into a 4-deep buffer: the fifth overwrites address 0.
  // Written values: 6,10,10,7,9 -> MemB = {9,10,10,7}.
  task automatic test_memb();
    exp_t e;
    logic [DW-1:0] rd_x [4] = '{10, 10, 7, 9};
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 1, 0, 1, 8'h00);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL memb_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
      if (i == 2) begin
        checks++;
        if ({BCount, BFull} !== {3'd3, 1'b0}) begin errors++; $display("FAIL memb_cnt3 got %0d/%0d want 3/0", BCount, BFull); end
      end
    end
    checks++;
    if ({AddrB, BCount, BFull} !== {2'd1, 3'd4, 1'b1}) begin
      errors++; $display("FAIL memb_full got addrb=%0d cnt=%0d full=%0d want 1/4/1", AddrB, BCount, BFull);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 1, 0, 0, 8'h00);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL memb_rd_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
      checks++;
      if (DOutB !== rd_x[i]) begin errors++; $display("FAIL memb_dout[%0d] got %0d want %0d", i, DOutB, rd_x[i]); end
    end
  endtask

  // Same-address write/read: the edge that writes 99 still reads the old word.
  task automatic test_raw();
    exp_t e;
    int guard = 0;
    while (AddrA !== 3'd3 && guard < 16) begin
      tick(1, 1, 0, 0, 0, 8'h00);
      e = sb.pop_front(); guard++;
      checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL raw_seek_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
    end
    checks++;
    if (AddrA !== 3'd3) begin errors++; $display("FAIL raw_seek got %0d want 3", AddrA); end
    tick(1, 0, 0, 1, 0, 8'd99);
    e = sb.pop_front(); checks++;
    if (ACur !== 8'd9) begin errors++; $display("FAIL raw_old got %0d want 9", ACur); end
    tick(1, 0, 0, 0, 0, 8'd0);
    e = sb.pop_front(); checks++;
    if (ACur !== 8'd99) begin errors++; $display("FAIL raw_new got %0d want 99", ACur); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [DW-1:0] acur_x [8] = '{10, 3, 7, 99, 2, 8, 5, 6};
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0, 1, 8'h00);
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL midrst_pre_sb got %h want %h mask %h", obs(), e.val, e.mask);
      end
    end
    tick(0, 1, 1, 1, 1, 8'h55);
    e = sb.pop_front(); checks++;
    if ({AddrA, AddrB, ACur, APrev, BCount, BFull} !== '0) begin
      errors++; $display("FAIL midrst_clear got %h want 0", {AddrA, AddrB, ACur, APrev, BCount, BFull});
    end
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 0, 0, 0, 8'h00);
      e = sb.pop_front(); checks++;
      if (ACur !== acur_x[i]) begin errors++; $display("FAIL midrst_keep[%0d] got %0d want %0d", i, ACur, acur_x[i]); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      tick(($urandom_range(0, 24) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 255)));
      e = sb.pop_front(); checks++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        errors++; $display("FAIL b2b_sb[%0d] got %h want %h mask %h", i, obs(), e.val, e.mask);
      end
    end
  endtask

  initial begin
    Reset = 0; IncA = 0; IncB = 0; WEA = 0; WEB = 0; DataInA = '0;
    test_reset();
    test_load();
    test_stream();
    test_memb();
    test_raw();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
